dlsc_pcie_s6_outbound_cpl: RTL
==============================

# dlsc_pcie_s6_outbound_cpl

Completion transmitter for the Spartan-6 PCIe endpoint. It sits between the local read-response logic and the core's 32-bit AXI transmit interface, and is the outbound counterpart of the inbound request parser. For each completion command it emits a 3-DW completion header (Cpl or CplD), followed by the matching payload DWs streamed from a separate payload channel.

## Interface
Parameters:
- `BUF_MIN`, default 1: minimum `tx_buf_av` needed before a TLP may start.

Ports:
- `clk`  in  1  user_clk_out; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `cfg_completer_id`  in  16  bus/dev/func placed in DW1[31:16].
- `tx_buf_av`  in  6  core transmit buffers available.
- `tx_ready`  in  1  s_axis_tx_tready.
- `tx_valid`  out  1  s_axis_tx_tvalid.
- `tx_last`  out  1  s_axis_tx_tlast.
- `tx_data`  out  32  s_axis_tx_tdata.
- `tx_src_dsc`  out  1  s_axis_tx_tuser[3], discontinue.
- `cmd_ready`  out  1  command accept.
- `cmd_valid`  in  1  command present.
- `cmd_tag`  in  8  request tag.
- `cmd_req_id`  in  16  requester ID.
- `cmd_tc`  in  3  traffic class.
- `cmd_attr`  in  2  attributes.
- `cmd_status`  in  3  completion status; 000 = SC.
- `cmd_bcm`  in  1  byte count modified.
- `cmd_bytes`  in  12  remaining byte count.
- `cmd_addr_lo`  in  7  lower address.
- `cmd_length`  in  10  payload DWs; 0 means 1024.
- `cplp_ready`  out  1  payload accept.
- `cplp_valid`  in  1  payload DW present.
- `cplp_last`  in  1  final payload DW.
- `cplp_data`  in  32  payload DW.
- `err_len`  out  1  sticky payload length mismatch.

## Operation
State machine: IDLE -> H0 -> H1 -> H2 -> (DATA | IDLE).
- IDLE: `cmd_ready` = `(tx_buf_av >= BUF_MIN)` and not mid-TLP. When `cmd_valid && cmd_ready`, register all cmd fields and go to H0.
- Data/no-data decision: `has_data` = `(cmd_status == 000)`.
- H0 word:
  - [31:24] = 0x4A if `has_data`, else 0x0A.
  - [22:20] = tc; [13:12] = attr.
  - [9:0] = length if `has_data`, else 0.
  - All other bits 0.
- H1 word: {completer_id, status, bcm, bytes}.
- H2 word: {req_id, tag, 1'b0, addr_lo}.
- Each header state holds `tx_valid` = 1 with a stable word until `tx_ready`, then advances.
- After H2: go to DATA if `has_data`, else IDLE. `tx_last` = 1 on H2 when there is no data.
- DATA is a pass-through:
  - `tx_valid` = `cplp_valid`; `cplp_ready` = `tx_ready`; `tx_data` = `cplp_data`.
  - A 10-bit counter loads `cmd_length` and decrements per accepted DW.
  - `tx_last` = `(cnt == 1)`. A load of 0 counts 1024 DWs via wrap-around.
  - The accepted DW with `tx_last` returns the state to IDLE.
- `cplp_ready` = 0 outside DATA.
- `tx_src_dsc` = 0 except as described under Configuration.

## Timing
- Reset values: all outputs 0, state IDLE, `err_len` 0. Reset asserted mid-TLP abandons the TLP immediately; the core resets with it.
- Command accept to H0 on `tx_valid`: 1 cycle.
- Throughput: back-to-back header beats at one beat per cycle.
  - Cpl occupies 3 cycles plus 1 IDLE cycle.
  - CplD of N DWs occupies N + 4 cycles minimum.
- DATA path is combinational from cplp to tx; there is no buffering. Header outputs are registered.
- `tx_buf_av` is sampled only in IDLE. A drop below `BUF_MIN` mid-TLP does not stall the TLP.
- `cmd_valid` asserted while busy: held off, with `cmd_ready` = 0.

## Configuration
- With `DLSC_PCIE_S6_OUTBOUND_CPL_CHECK_EN` defined, the block checks payload framing:
  - `cplp_last` on a DW where `cnt != 1`, or `cnt == 1` without `cplp_last`, sets `err_len` (sticky until reset).
  - An early `cplp_last` also drives `tx_src_dsc` = 1 on that beat and returns the state to IDLE.
- Without the macro:
  - `err_len` and `tx_src_dsc` are tied 0.
  - `cplp_last` is ignored; framing comes from the counter only.

## Test plan
- **CplD, length 1, status 0, tag 0x5A, bytes 4, addr_lo 0x10, id 0x0100:**
  - required tx sequence: 0x4A000001, 0x01000004, {req_id, 0x5A, 0x10}, data with `tx_last`.
- **UR completion (status 001):**
  - 3 beats, H0 = 0x0A000000, `tx_last` on beat 3, `cplp_ready` never asserted.
- **CplD with length 0 (1024 DWs), random `tx_ready` and `cplp_valid` gaps:**
  - exactly 1024 payload DWs forwarded in order; `tx_last` only on DW 1024.
- **`tx_buf_av` = 0 with `cmd_valid` high:**
  - `cmd_ready` stays 0.
  - Raising `tx_buf_av` to 1 gives accept that cycle and H0 on the next.
- **Reset asserted during DATA beat 3 of 8:**
  - `tx_valid` and `cplp_ready` go 0 asynchronously; the next command starts cleanly at H0.
- **With CHECK_EN, `cplp_last` on DW 2 of 4:**
  - `tx_src_dsc` = 1 on that beat, `err_len` = 1 and sticky, state returns to IDLE.

Source files
------------

// File: rtl/dlsc_pcie_s6_outbound_cpl.sv
// dlsc_pcie_s6_outbound_cpl
// Completion transmitter for the Spartan-6 PCIe endpoint. Turns completion
// commands into a 3-DW Cpl/CplD header on the core's 32-bit AXI transmit
// interface, then passes payload DWs straight through from the payload channel.
//
// Optional build macro: DLSC_PCIE_S6_OUTBOUND_CPL_CHECK_EN
//   When defined, payload framing (cplp_last vs. the DW counter) is checked:
//   mismatches set the sticky err_len flag, and an early cplp_last ends the
//   TLP with tx_src_dsc (discontinue) on that beat.
//   When undefined, cplp_last is ignored and err_len/tx_src_dsc stay 0.

module dlsc_pcie_s6_outbound_cpl #(
  parameter int BUF_MIN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cfg_completer_id,
  input  logic [5:0]  tx_buf_av,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic        tx_last,
  output logic [31:0] tx_data,
  output logic        tx_src_dsc,
  output logic        cmd_ready,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_tag,
  input  logic [15:0] cmd_req_id,
  input  logic [2:0]  cmd_tc,
  input  logic [1:0]  cmd_attr,
  input  logic [2:0]  cmd_status,
  input  logic        cmd_bcm,
  input  logic [11:0] cmd_bytes,
  input  logic [6:0]  cmd_addr_lo,
  input  logic [9:0]  cmd_length,
  output logic        cplp_ready,
  input  logic        cplp_valid,
  input  logic        cplp_last,
  input  logic [31:0] cplp_data,
  output logic        err_len
);

  localparam logic [5:0] BUF_MIN_W = 6'(BUF_MIN);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_H0   = 3'd1,
    ST_H1   = 3'd2,
    ST_H2   = 3'd3,
    ST_DATA = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;

  // Command fields captured at accept; header words are built only from these.
  logic [7:0]  tag_r;
  logic [15:0] req_id_r;
  logic [15:0] cpl_id_r;
  logic [2:0]  tc_r;
  logic [1:0]  attr_r;
  logic [2:0]  status_r;
  logic        bcm_r;
  logic [11:0] bytes_r;
  logic [6:0]  addr_lo_r;
  logic [9:0]  length_r;
  logic        has_data_r;

  // Remaining payload DWs; a load of 0 wraps through 1023..1 to give 1024.
  logic [9:0]  cnt_r;

  logic        buf_ok_s;
  logic        cmd_acc_s;
  logic        data_beat_s;
  logic        cnt_one_s;
  logic        data_end_s;
  logic        early_last_s;
  logic        err_set_s;

`ifndef DLSC_PCIE_S6_OUTBOUND_CPL_CHECK_EN
  // cplp_last has no role when framing checks are compiled out.
  logic        unused_cplp_last_s;
  assign unused_cplp_last_s = cplp_last;
`endif

  // Handshake qualifiers and payload framing decisions.
  always_comb begin
    buf_ok_s    = (tx_buf_av >= BUF_MIN_W);
    cmd_acc_s   = (state_r == ST_IDLE) && buf_ok_s && cmd_valid;
    data_beat_s = (state_r == ST_DATA) && cplp_valid && tx_ready;
    cnt_one_s   = (cnt_r == 10'd1);
`ifdef DLSC_PCIE_S6_OUTBOUND_CPL_CHECK_EN
    early_last_s = (state_r == ST_DATA) && cplp_valid && cplp_last && !cnt_one_s;
    err_set_s    = data_beat_s && (cplp_last != cnt_one_s);
    data_end_s   = data_beat_s && (cnt_one_s || cplp_last);
`else
    early_last_s = 1'b0;
    err_set_s    = 1'b0;
    data_end_s   = data_beat_s && cnt_one_s;
`endif
  end

  // Next-state logic; header beats advance only when the core takes them.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_acc_s) state_nxt_s = ST_H0;
        else           state_nxt_s = ST_IDLE;
      end
      ST_H0: begin
        if (tx_ready) state_nxt_s = ST_H1;
        else          state_nxt_s = ST_H0;
      end
      ST_H1: begin
        if (tx_ready) state_nxt_s = ST_H2;
        else          state_nxt_s = ST_H1;
      end
      ST_H2: begin
        if (tx_ready) state_nxt_s = has_data_r ? ST_DATA : ST_IDLE;
        else          state_nxt_s = ST_H2;
      end
      ST_DATA: begin
        if (data_end_s) state_nxt_s = ST_IDLE;
        else            state_nxt_s = ST_DATA;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode: header beats come from registered fields, payload is a
  // combinational pass-through of the cplp channel.
  always_comb begin
    tx_valid   = 1'b0;
    tx_last    = 1'b0;
    tx_data    = 32'd0;
    tx_src_dsc = 1'b0;
    cmd_ready  = 1'b0;
    cplp_ready = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cmd_ready = buf_ok_s;
      end
      ST_H0: begin
        tx_valid = 1'b1;
        tx_data  = {(has_data_r ? 8'h4A : 8'h0A), 1'b0, tc_r, 6'd0, attr_r, 2'd0,
                    (has_data_r ? length_r : 10'd0)};
      end
      ST_H1: begin
        tx_valid = 1'b1;
        tx_data  = {cpl_id_r, status_r, bcm_r, bytes_r};
      end
      ST_H2: begin
        tx_valid = 1'b1;
        tx_last  = !has_data_r;
        tx_data  = {req_id_r, tag_r, 1'b0, addr_lo_r};
      end
      ST_DATA: begin
        tx_valid   = cplp_valid;
        tx_data    = cplp_data;
        tx_last    = cnt_one_s;
        tx_src_dsc = early_last_s;
        cplp_ready = tx_ready;
      end
      default: begin
        tx_valid = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Capture the command when it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_r      <= 8'd0;
      req_id_r   <= 16'd0;
      cpl_id_r   <= 16'd0;
      tc_r       <= 3'd0;
      attr_r     <= 2'd0;
      status_r   <= 3'd0;
      bcm_r      <= 1'b0;
      bytes_r    <= 12'd0;
      addr_lo_r  <= 7'd0;
      length_r   <= 10'd0;
      has_data_r <= 1'b0;
    end else if (cmd_acc_s) begin
      tag_r      <= cmd_tag;
      req_id_r   <= cmd_req_id;
      cpl_id_r   <= cfg_completer_id;
      tc_r       <= cmd_tc;
      attr_r     <= cmd_attr;
      status_r   <= cmd_status;
      bcm_r      <= cmd_bcm;
      bytes_r    <= cmd_bytes;
      addr_lo_r  <= cmd_addr_lo;
      length_r   <= cmd_length;
      has_data_r <= (cmd_status == 3'b000);
    end
  end

  // Payload DW counter: load at accept, count down per accepted payload DW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt_r <= 10'd0;
    else if (cmd_acc_s)   cnt_r <= cmd_length;
    else if (data_beat_s) cnt_r <= cnt_r - 10'd1;
  end

  // Sticky framing error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         err_len <= 1'b0;
    else if (err_set_s) err_len <= 1'b1;
  end

endmodule
